// File: rtl/trig_receiver.sv
// Radar trigger receiver: synchronises the trigger line, measures edge-to-edge
// period, tracks lock against a nominal period and counts misses/errors.
module trig_receiver #(
  parameter int SYNC_STAGES    = 2,
  parameter int NOMINAL_PERIOD = 300300,
  parameter int TOLERANCE      = 16,
  parameter int LOCK_COUNT     = 4,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                 IN_CLK,
  input  logic                 IN_RESETN,
  input  logic                 RADAR_TRIG,
  output logic                 TRIG_PULSE,
  output logic [CNT_WIDTH-1:0] PERIOD,
  output logic                 PERIOD_VALID,
  output logic                 LOCKED,
  output logic [1:0]           STATE,
  output logic [15:0]          MISS_COUNT,
  output logic [15:0]          ERR_COUNT
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_LOST    = 2'd3
  } state_t;

  localparam int GW = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_WIDTH:0] PER_LO  = (CNT_WIDTH+1)'(NOMINAL_PERIOD - TOLERANCE);
  localparam logic [CNT_WIDTH:0] PER_HI  = (CNT_WIDTH+1)'(NOMINAL_PERIOD + TOLERANCE);
  localparam logic [CNT_WIDTH:0] PER_TMO = (CNT_WIDTH+1)'(NOMINAL_PERIOD + TOLERANCE + 1);

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic [CNT_WIDTH-1:0]   elap;
  logic [GW-1:0]          good;
  logic [CNT_WIDTH:0]     elap_inc;
  logic                   edge_det;
  logic                   in_tol;
  logic                   timeout;

  // One extra bit so a saturated ELAP never compares as in-tolerance after wrap.
  assign elap_inc = {1'b0, elap} + 1'b1;
  assign edge_det = sync[SYNC_STAGES-1] & ~prev;
  assign in_tol   = (elap_inc >= PER_LO) && (elap_inc <= PER_HI);
  assign timeout  = !edge_det && (elap_inc == PER_TMO);

  assign STATE  = state;
  assign LOCKED = (state == ST_LOCKED);

  always_ff @(posedge IN_CLK or negedge IN_RESETN) begin
    if (!IN_RESETN) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], RADAR_TRIG};
    end
  end

  always_ff @(posedge IN_CLK or negedge IN_RESETN) begin
    if (!IN_RESETN) begin
      state        <= ST_IDLE;
      prev         <= 1'b0;
      elap         <= '0;
      good         <= '0;
      TRIG_PULSE   <= 1'b0;
      PERIOD       <= '0;
      PERIOD_VALID <= 1'b0;
      MISS_COUNT   <= '0;
      ERR_COUNT    <= '0;
    end else begin
      prev         <= sync[SYNC_STAGES-1];
      TRIG_PULSE   <= edge_det;
      PERIOD_VALID <= 1'b0;

      if (state == ST_IDLE || edge_det) begin
        elap <= '0;
      end else if (elap != '1) begin
        elap <= elap + 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (edge_det) begin
            state <= ST_ACQUIRE;
            good  <= '0;
          end
        end
        ST_ACQUIRE: begin
          if (edge_det) begin
            PERIOD       <= elap_inc[CNT_WIDTH-1:0];
            PERIOD_VALID <= 1'b1;
            if (in_tol) begin
              good <= good + 1'b1;
              if (good + 1'b1 == GW'(LOCK_COUNT)) begin
                state <= ST_LOCKED;
              end
            end else begin
              good <= '0;
            end
          end else if (timeout) begin
            state <= ST_LOST;
          end
        end
        ST_LOCKED: begin
          if (edge_det) begin
            PERIOD       <= elap_inc[CNT_WIDTH-1:0];
            PERIOD_VALID <= 1'b1;
            if (!in_tol) begin
              state <= ST_ACQUIRE;
              good  <= '0;
              if (ERR_COUNT != 16'hFFFF) begin
                ERR_COUNT <= ERR_COUNT + 1'b1;
              end
            end
          end else if (timeout) begin
            state <= ST_LOST;
            if (MISS_COUNT != 16'hFFFF) begin
              MISS_COUNT <= MISS_COUNT + 1'b1;
            end
          end
        end
        ST_LOST: begin
          // First edge after a loss only restarts the measurement.
          if (edge_det) begin
            state <= ST_ACQUIRE;
            good  <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trig_receiver.sv
// Directed bench for trig_receiver: a scaled-down main instance for lock and
// tolerance behaviour, plus a tiny instance for the miss-counter saturation.
module tb_trig_receiver;

  localparam int NOM   = 1000;
  localparam int TOL   = 16;
  localparam int S_NOM = 8;

  logic        clk;
  logic        rst_n;
  logic        trig;
  logic        trig_s;

  logic        pulse, valid, locked;
  logic [31:0] period;
  logic [1:0]  state;
  logic [15:0] miss, err;

  logic        pulse_s, valid_s, locked_s;
  logic [31:0] period_s;
  logic [1:0]  state_s;
  logic [15:0] miss_s, err_s;

  int total = 0;
  int bad   = 0;
  int vcount = 0;

  trig_receiver #(
    .SYNC_STAGES(2), .NOMINAL_PERIOD(NOM), .TOLERANCE(TOL), .LOCK_COUNT(4), .CNT_WIDTH(32)
  ) dut (
    .IN_CLK(clk), .IN_RESETN(rst_n), .RADAR_TRIG(trig),
    .TRIG_PULSE(pulse), .PERIOD(period), .PERIOD_VALID(valid),
    .LOCKED(locked), .STATE(state), .MISS_COUNT(miss), .ERR_COUNT(err)
  );

  trig_receiver #(
    .SYNC_STAGES(2), .NOMINAL_PERIOD(S_NOM), .TOLERANCE(0), .LOCK_COUNT(1), .CNT_WIDTH(32)
  ) dut_s (
    .IN_CLK(clk), .IN_RESETN(rst_n), .RADAR_TRIG(trig_s),
    .TRIG_PULSE(pulse_s), .PERIOD(period_s), .PERIOD_VALID(valid_s),
    .LOCKED(locked_s), .STATE(state_s), .MISS_COUNT(miss_s), .ERR_COUNT(err_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (valid) vcount <= vcount + 1;

  typedef struct {
    int          gap;
    logic [1:0]  st;
    logic        vld;
    logic [31:0] per;
    logic [15:0] err;
  } vec_t;

  vec_t tbl[13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Raise the trigger; returns at the sample point where TRIG_PULSE is expected.
  task automatic pulse_edge(input bit which);
    if (which) trig_s = 1'b1; else trig = 1'b1;
    wait_ticks(3);
    if (which) trig_s = 1'b0; else trig = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{0,    2'd1, 1'b0, 32'd0,    16'd0};
    tbl[1]  = '{1000, 2'd1, 1'b1, 32'd1000, 16'd0};
    tbl[2]  = '{1000, 2'd1, 1'b1, 32'd1000, 16'd0};
    tbl[3]  = '{1000, 2'd1, 1'b1, 32'd1000, 16'd0};
    tbl[4]  = '{1000, 2'd2, 1'b1, 32'd1000, 16'd0};
    tbl[5]  = '{1016, 2'd2, 1'b1, 32'd1016, 16'd0};
    tbl[6]  = '{1017, 2'd1, 1'b1, 32'd1017, 16'd1};
    tbl[7]  = '{984,  2'd1, 1'b1, 32'd984,  16'd1};
    tbl[8]  = '{983,  2'd1, 1'b1, 32'd983,  16'd1};
    tbl[9]  = '{1000, 2'd1, 1'b1, 32'd1000, 16'd1};
    tbl[10] = '{1000, 2'd1, 1'b1, 32'd1000, 16'd1};
    tbl[11] = '{1000, 2'd1, 1'b1, 32'd1000, 16'd1};
    tbl[12] = '{1000, 2'd2, 1'b1, 32'd1000, 16'd1};

    rst_n = 1'b0; trig = 1'b0; trig_s = 1'b0;
    for (int k = 0; k < 6; k++) begin
      trig = ~trig;
      tick();
      check("rst_pulse", {63'd0, pulse}, 64'd0);
      check("rst_state", {62'd0, state}, 64'd0);
    end
    check("rst_period", {32'd0, period}, 64'd0);
    check("rst_valid",  {63'd0, valid}, 64'd0);
    check("rst_locked", {63'd0, locked}, 64'd0);
    check("rst_miss",   {48'd0, miss}, 64'd0);
    check("rst_err",    {48'd0, err}, 64'd0);
    trig = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    wait_ticks(4);
    check("idle_state", {62'd0, state}, 64'd0);

    vcount = 0;
    for (int i = 0; i < 13; i++) begin
      if (i > 0) wait_ticks(tbl[i].gap - 4);
      pulse_edge(1'b0);
      $display("edge %0d gap=%0d state=%0d valid=%0d period=%0d err=%0d",
               i, tbl[i].gap, state, valid, period, err);
      check("vec_pulse",  {63'd0, pulse}, 64'd1);
      check("vec_state",  {62'd0, state}, {62'd0, tbl[i].st});
      check("vec_locked", {63'd0, locked}, {63'd0, (tbl[i].st == 2'd2)});
      check("vec_valid",  {63'd0, valid}, {63'd0, tbl[i].vld});
      check("vec_period", {32'd0, period}, {32'd0, tbl[i].per});
      check("vec_err",    {48'd0, err}, {48'd0, tbl[i].err});
      tick();
      check("vec_pulse_w", {63'd0, pulse}, 64'd0);
      check("vec_valid_w", {63'd0, valid}, 64'd0);
      if (i == 4) check("lock_strobes", vcount, 64'd4);
    end

    // Locked with no further edges: timeout at ELAP+1 = NOM+TOL+1.
    wait_ticks(1015);
    check("miss_before", {62'd0, state}, 64'd2);
    tick();
    $display("miss: state=%0d miss=%0d", state, miss);
    check("miss_state",  {62'd0, state}, 64'd3);
    check("miss_count",  {48'd0, miss}, 64'd1);
    check("miss_locked", {63'd0, locked}, 64'd0);
    pulse_edge(1'b0);
    check("relock_state", {62'd0, state}, 64'd1);
    check("relock_valid", {63'd0, valid}, 64'd0);
    check("relock_pulse", {63'd0, pulse}, 64'd1);
    tick();
    wait_ticks(NOM - 4);
    pulse_edge(1'b0);
    check("reacq_valid",  {63'd0, valid}, 64'd1);
    check("reacq_period", {32'd0, period}, 64'd1000);
    tick();
    wait_ticks(1015);
    check("acq_to_before", {62'd0, state}, 64'd1);
    tick();
    $display("acquire timeout: state=%0d miss=%0d", state, miss);
    check("acq_to_state", {62'd0, state}, 64'd3);
    check("acq_to_miss",  {48'd0, miss}, 64'd1);

    // Small instance: one real miss, then preload near saturation.
    pulse_edge(1'b1);
    check("s_acq", {62'd0, state_s}, 64'd1);
    wait_ticks(S_NOM - 3);
    pulse_edge(1'b1);
    check("s_lock", {62'd0, state_s}, 64'd2);
    wait_ticks(S_NOM);
    check("s_lock_hold", {62'd0, state_s}, 64'd2);
    tick();
    check("s_lost", {62'd0, state_s}, 64'd3);
    check("s_miss1", {48'd0, miss_s}, 64'd1);
    force dut_s.MISS_COUNT = 16'hFFFE;
    tick();
    release dut_s.MISS_COUNT;
    tick();
    check("s_preload", {48'd0, miss_s}, 64'hFFFE);
    for (int r = 0; r < 2; r++) begin
      pulse_edge(1'b1);
      wait_ticks(S_NOM - 3);
      pulse_edge(1'b1);
      check("s_relock", {62'd0, state_s}, 64'd2);
      wait_ticks(S_NOM + 1);
      $display("sat miss %0d: state=%0d miss=%0h", r, state_s, miss_s);
      check("s_sat_state", {62'd0, state_s}, 64'd3);
      check("s_sat_miss",  {48'd0, miss_s}, 64'hFFFF);
    end

    // Asynchronous reset in the middle of a period.
    pulse_edge(1'b0);
    wait_ticks(100);
    #3;
    rst_n = 1'b0;
    #1;
    $display("async reset: state=%0d period=%0d miss=%0d err=%0d miss_s=%0h",
             state, period, miss, err, miss_s);
    check("ar_state",  {62'd0, state}, 64'd0);
    check("ar_period", {32'd0, period}, 64'd0);
    check("ar_err",    {48'd0, err}, 64'd0);
    check("ar_miss",   {48'd0, miss}, 64'd0);
    check("ar_miss_s", {48'd0, miss_s}, 64'd0);
    check("ar_locked", {63'd0, locked}, 64'd0);
    tick();
    rst_n = 1'b1;
    wait_ticks(3);
    check("post_state", {62'd0, state}, 64'd0);
    check("post_pulse", {63'd0, pulse}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
